// File: rtl/rv32_ctrl_pkg.sv
// Shared encodings for the RV32IM decode/control stage.
// Holds opcode constants, the control-field encodings driven onto the
// ID/EX boundary, the bubble bundle and the FSM state type.
package rv32_ctrl_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_IMM = 2'b10;
   localparam logic [1:0] WB_PC4 = 2'b11;

   localparam logic [2:0] IMM_U   = 3'b000;
   localparam logic [2:0] IMM_J   = 3'b001;
   localparam logic [2:0] IMM_S   = 3'b010;
   localparam logic [2:0] IMM_B   = 3'b011;
   localparam logic [2:0] IMM_I   = 3'b100;
   localparam logic [2:0] IMM_ISH = 3'b101;
   localparam logic [2:0] IMM_IU  = 3'b111;

   // Branches carry their FUNCT3 directly; 010/011 are free for these two.
   localparam logic [2:0] BJ_NONE = 3'b010;
   localparam logic [2:0] BJ_JUMP = 3'b011;

   localparam logic [3:0] MEM_NONE = 4'b0000;
   localparam logic [3:0] MEM_LB   = 4'b1000;
   localparam logic [3:0] MEM_LH   = 4'b1001;
   localparam logic [3:0] MEM_LW   = 4'b1010;
   localparam logic [3:0] MEM_LBU  = 4'b1100;
   localparam logic [3:0] MEM_LHU  = 4'b1101;
   localparam logic [3:0] MEM_SB   = 4'b1011;
   localparam logic [3:0] MEM_SH   = 4'b1110;
   localparam logic [3:0] MEM_SW   = 4'b1111;

   typedef struct packed {
      logic       op1sel;
      logic       op2sel;
      logic       reg_write_en;
      logic [1:0] wb_sel;
      logic [4:0] aluop;
      logic [2:0] branch_jump;
      logic [2:0] imm_sel;
      logic [3:0] mem_rw;
   } ctrl_bundle_t;

   localparam ctrl_bundle_t CTRL_BUBBLE = '{
      op1sel:       1'b0,
      op2sel:       1'b0,
      reg_write_en: 1'b0,
      wb_sel:       WB_ALU,
      aluop:        5'b00000,
      branch_jump:  BJ_NONE,
      imm_sel:      IMM_U,
      mem_rw:       MEM_NONE
   };

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_MUL_WAIT = 2'd1,
      ST_DIV_WAIT = 2'd2
   } fsm_state_t;

endpackage

// File: rtl/control_unit_pipelined_if.sv
// Handshake and control-bundle bus of the decode/control stage.
// master: upstream/downstream side (drives INSTR, IN_VALID, STALL_IN, FLUSH).
// slave:  the control unit (drives IN_READY and the registered bundle).
interface control_unit_pipelined_if;
   logic [31:0] INSTR;
   logic        IN_VALID;
   logic        IN_READY;
   logic        STALL_IN;
   logic        FLUSH;
   logic        OUT_VALID;
   logic        OP1SEL;
   logic        OP2SEL;
   logic        REG_WRITE_EN;
   logic [1:0]  WB_SEL;
   logic [4:0]  ALUOP;
   logic [2:0]  BRANCH_JUMP;
   logic [2:0]  IMM_SEL;
   logic [3:0]  MEM_RW;
   logic        MDU_BUSY;
   logic        ILLEGAL;

   modport master (
      output INSTR, IN_VALID, STALL_IN, FLUSH,
      input  IN_READY, OUT_VALID, OP1SEL, OP2SEL, REG_WRITE_EN, WB_SEL,
             ALUOP, BRANCH_JUMP, IMM_SEL, MEM_RW, MDU_BUSY, ILLEGAL
   );

   modport slave (
      input  INSTR, IN_VALID, STALL_IN, FLUSH,
      output IN_READY, OUT_VALID, OP1SEL, OP2SEL, REG_WRITE_EN, WB_SEL,
             ALUOP, BRANCH_JUMP, IMM_SEL, MEM_RW, MDU_BUSY, ILLEGAL
   );
endinterface

// File: rtl/rv32_decode.sv
// Combinational RV32IM decoder.
// Ports: instr (in, 32) instruction word; ctrl (out) control bundle;
// is_mop / is_div (out) M-extension op and its divide flavour;
// illegal (out) opcode or FUNCT3 that cannot be decoded.
module rv32_decode
   import rv32_ctrl_pkg::*;
#(
   parameter int M_EXT = 1
) (
   input  logic [31:0]  instr,
   output ctrl_bundle_t ctrl,
   output logic         is_mop,
   output logic         is_div,
   output logic         illegal
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       f7_5;
   logic       f7_0;
   logic       is_shift;
   logic       unused_fields;

   assign opcode   = instr[6:0];
   assign funct3   = instr[14:12];
   assign f7_5     = instr[30];
   assign f7_0     = instr[25];
   assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
   // Register indices and remaining immediate bits are consumed downstream.
   assign unused_fields = ^{instr[31], instr[29:26], instr[24:15], instr[11:7]};

   always_comb begin
      ctrl    = CTRL_BUBBLE;
      is_mop  = 1'b0;
      is_div  = 1'b0;
      illegal = 1'b0;
      case (opcode)
         OPC_LUI: begin
            ctrl.op2sel       = 1'b1;
            ctrl.reg_write_en = 1'b1;
            ctrl.wb_sel       = WB_IMM;
            ctrl.imm_sel      = IMM_U;
         end
         OPC_AUIPC: begin
            ctrl.op1sel       = 1'b1;
            ctrl.op2sel       = 1'b1;
            ctrl.reg_write_en = 1'b1;
            ctrl.imm_sel      = IMM_U;
         end
         OPC_JAL: begin
            ctrl.op1sel       = 1'b1;
            ctrl.op2sel       = 1'b1;
            ctrl.reg_write_en = 1'b1;
            ctrl.wb_sel       = WB_PC4;
            ctrl.branch_jump  = BJ_JUMP;
            ctrl.imm_sel      = IMM_J;
         end
         OPC_JALR: begin
            illegal           = (funct3 != 3'b000);
            ctrl.op2sel       = 1'b1;
            ctrl.reg_write_en = 1'b1;
            ctrl.wb_sel       = WB_PC4;
            ctrl.branch_jump  = BJ_JUMP;
            ctrl.imm_sel      = IMM_I;
         end
         OPC_BRANCH: begin
            // 010/011 are not branches and would alias the none/jump codes.
            illegal          = (funct3[2:1] == 2'b01);
            ctrl.branch_jump = funct3;
            ctrl.imm_sel     = IMM_B;
         end
         OPC_LOAD: begin
            ctrl.op2sel       = 1'b1;
            ctrl.reg_write_en = 1'b1;
            ctrl.wb_sel       = WB_MEM;
            ctrl.imm_sel      = IMM_I;
            case (funct3)
               3'b000:  ctrl.mem_rw = MEM_LB;
               3'b001:  ctrl.mem_rw = MEM_LH;
               3'b010:  ctrl.mem_rw = MEM_LW;
               3'b100:  ctrl.mem_rw = MEM_LBU;
               3'b101:  ctrl.mem_rw = MEM_LHU;
               default: illegal = 1'b1;
            endcase
         end
         OPC_STORE: begin
            ctrl.op2sel  = 1'b1;
            ctrl.imm_sel = IMM_S;
            case (funct3)
               3'b000:  ctrl.mem_rw = MEM_SB;
               3'b001:  ctrl.mem_rw = MEM_SH;
               3'b010:  ctrl.mem_rw = MEM_SW;
               default: illegal = 1'b1;
            endcase
         end
         OPC_OP_IMM: begin
            ctrl.op2sel       = 1'b1;
            ctrl.reg_write_en = 1'b1;
            if (is_shift) begin
               ctrl.aluop   = {funct3, f7_5, f7_0};
               ctrl.imm_sel = IMM_ISH;
            end else begin
               // Upper immediate bits sit where FUNCT7 would be; ignore them.
               ctrl.aluop   = {funct3, 2'b00};
               ctrl.imm_sel = (funct3 == 3'b011) ? IMM_IU : IMM_I;
            end
         end
         OPC_OP: begin
            ctrl.reg_write_en = 1'b1;
            ctrl.aluop        = {funct3, f7_5, f7_0};
            if (f7_0) begin
               if (M_EXT != 0) begin
                  is_mop = 1'b1;
                  is_div = funct3[2];
               end else begin
                  illegal = 1'b1;
               end
            end
         end
         OPC_FENCE, OPC_SYSTEM: ;
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/control_unit_pipelined.sv
// Registered RV32IM decode/control stage (control half of ID/EX).
// Ports: CLK clock; RESETN async active-low reset; bus (slave modport)
// carrying INSTR/IN_VALID/IN_READY/STALL_IN/FLUSH and the registered bundle.
//
// state        | meaning
// ST_IDLE      | issuing; one instruction accepted per non-stalled cycle
// ST_MUL_WAIT  | multiply occupies execute; bubbles until counter expires
// ST_DIV_WAIT  | divide/remainder occupies execute; bubbles until counter expires
module control_unit_pipelined
   import rv32_ctrl_pkg::*;
#(
   parameter int M_EXT       = 1,
   parameter int MUL_LATENCY = 2,
   parameter int DIV_LATENCY = 33
) (
   input logic                      CLK,
   input logic                      RESETN,
   control_unit_pipelined_if.slave  bus
);

   localparam int MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LATENCY - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LATENCY - 1);

   fsm_state_t       state;
   logic [CNT_W-1:0] cnt;
   ctrl_bundle_t     ctrl_q;
   logic             out_valid_q;
   logic             illegal_q;

   ctrl_bundle_t     dec_ctrl;
   logic             dec_is_mop;
   logic             dec_is_div;
   logic             dec_illegal;
   logic             in_ready;
   logic             accept;

   rv32_decode #(.M_EXT(M_EXT)) u_decode (
      .instr   (bus.INSTR),
      .ctrl    (dec_ctrl),
      .is_mop  (dec_is_mop),
      .is_div  (dec_is_div),
      .illegal (dec_illegal)
   );

   assign in_ready = (state == ST_IDLE) && !bus.STALL_IN;
   assign accept   = bus.IN_VALID && in_ready && !bus.FLUSH;

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         ctrl_q      <= CTRL_BUBBLE;
         out_valid_q <= 1'b0;
         illegal_q   <= 1'b0;
      end else if (bus.FLUSH) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         ctrl_q      <= CTRL_BUBBLE;
         out_valid_q <= 1'b0;
         illegal_q   <= 1'b0;
      end else if (bus.STALL_IN) begin
         // hold everything, counter included
      end else if (state != ST_IDLE) begin
         ctrl_q      <= CTRL_BUBBLE;
         out_valid_q <= 1'b0;
         illegal_q   <= 1'b0;
         cnt         <= cnt - CNT_W'(1);
         if (cnt == CNT_W'(1)) begin
            state <= ST_IDLE;
         end
      end else if (accept) begin
         if (dec_illegal) begin
            ctrl_q      <= CTRL_BUBBLE;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b1;
         end else begin
            ctrl_q      <= dec_ctrl;
            out_valid_q <= 1'b1;
            illegal_q   <= 1'b0;
            // A latency of one needs no wait cycles, so the FSM stays idle.
            if (dec_is_mop && dec_is_div && (DIV_LOAD != '0)) begin
               state <= ST_DIV_WAIT;
               cnt   <= DIV_LOAD;
            end else if (dec_is_mop && !dec_is_div && (MUL_LOAD != '0)) begin
               state <= ST_MUL_WAIT;
               cnt   <= MUL_LOAD;
            end
         end
      end else begin
         ctrl_q      <= CTRL_BUBBLE;
         out_valid_q <= 1'b0;
         illegal_q   <= 1'b0;
      end
   end

   assign bus.IN_READY     = in_ready;
   assign bus.OUT_VALID    = out_valid_q;
   assign bus.OP1SEL       = ctrl_q.op1sel;
   assign bus.OP2SEL       = ctrl_q.op2sel;
   assign bus.REG_WRITE_EN = ctrl_q.reg_write_en;
   assign bus.WB_SEL       = ctrl_q.wb_sel;
   assign bus.ALUOP        = ctrl_q.aluop;
   assign bus.BRANCH_JUMP  = ctrl_q.branch_jump;
   assign bus.IMM_SEL      = ctrl_q.imm_sel;
   assign bus.MEM_RW       = ctrl_q.mem_rw;
   assign bus.MDU_BUSY     = (state != ST_IDLE);
   assign bus.ILLEGAL      = illegal_q;

endmodule

// File: tb/tb_control_unit_pipelined.sv
// Directed testbench for control_unit_pipelined.
// Bundle vectors are packed as {op1,op2,rw,wb[1:0],aluop[4:0],bj[2:0],imm[2:0],mem[3:0]}.
module tb_control_unit_pipelined;

   localparam logic [31:0] I_ADD  = 32'h003100B3;
   localparam logic [31:0] I_DIV  = 32'h023140B3;
   localparam logic [31:0] I_MUL  = 32'h023100B3;
   localparam logic [31:0] I_BEQ  = 32'h00208463;
   localparam logic [31:0] I_BAD  = 32'h0000007F;
   localparam logic [19:0] BUBBLE = {1'b0, 1'b0, 1'b0, 2'b00, 5'b00000, 3'b010, 3'b000, 4'b0000};

   logic clk = 1'b0;
   logic resetn;
   int   total = 0;
   int   bad = 0;

   logic [31:0] tv_instr [13];
   logic [19:0] tv_exp   [13];

   always #5 clk = ~clk;

   control_unit_pipelined_if bus ();
   control_unit_pipelined_if bus_nm ();

   control_unit_pipelined #(.M_EXT(1), .MUL_LATENCY(2), .DIV_LATENCY(33)) dut (
      .CLK(clk), .RESETN(resetn), .bus(bus));

   control_unit_pipelined #(.M_EXT(0), .MUL_LATENCY(2), .DIV_LATENCY(33)) dut_nm (
      .CLK(clk), .RESETN(resetn), .bus(bus_nm));

   function automatic logic [19:0] bundle();
      return {bus.OP1SEL, bus.OP2SEL, bus.REG_WRITE_EN, bus.WB_SEL, bus.ALUOP,
              bus.BRANCH_JUMP, bus.IMM_SEL, bus.MEM_RW};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      total++; if (bus.OUT_VALID !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", bus.OUT_VALID); end
      total++; if (bus.MDU_BUSY !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", bus.MDU_BUSY); end
      total++; if (bus.IN_READY !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", bus.IN_READY); end
      tick();
      tick();
      resetn = 1'b1;
      tick();
      total++; if (bundle() !== BUBBLE) begin bad++; $display("FAIL rel_bundle: got %h want %h", bundle(), BUBBLE); end
      total++; if (bus.OUT_VALID !== 1'b0) begin bad++; $display("FAIL rel_out_valid: got %b want 0", bus.OUT_VALID); end
      total++; if (bus.ILLEGAL !== 1'b0) begin bad++; $display("FAIL rel_illegal: got %b want 0", bus.ILLEGAL); end
      total++; if (bus.IN_READY !== 1'b1) begin bad++; $display("FAIL rel_in_ready: got %b want 1", bus.IN_READY); end
   endtask

   task automatic test_decode_table();
      tv_instr[0]  = I_ADD;         tv_exp[0]  = {1'b0, 1'b0, 1'b1, 2'b00, 5'b00000, 3'b010, 3'b000, 4'b0000};
      tv_instr[1]  = 32'h00312023;  tv_exp[1]  = {1'b0, 1'b1, 1'b0, 2'b00, 5'b00000, 3'b010, 3'b010, 4'b1111};
      tv_instr[2]  = 32'h00012083;  tv_exp[2]  = {1'b0, 1'b1, 1'b1, 2'b01, 5'b00000, 3'b010, 3'b100, 4'b1010};
      tv_instr[3]  = 32'h123450B7;  tv_exp[3]  = {1'b0, 1'b1, 1'b1, 2'b10, 5'b00000, 3'b010, 3'b000, 4'b0000};
      tv_instr[4]  = 32'h008000EF;  tv_exp[4]  = {1'b1, 1'b1, 1'b1, 2'b11, 5'b00000, 3'b011, 3'b001, 4'b0000};
      tv_instr[5]  = I_BEQ;         tv_exp[5]  = {1'b0, 1'b0, 1'b0, 2'b00, 5'b00000, 3'b000, 3'b011, 4'b0000};
      tv_instr[6]  = 32'h40315093;  tv_exp[6]  = {1'b0, 1'b1, 1'b1, 2'b00, 5'b10110, 3'b010, 3'b101, 4'b0000};
      tv_instr[7]  = 32'hFFF10093;  tv_exp[7]  = {1'b0, 1'b1, 1'b1, 2'b00, 5'b00000, 3'b010, 3'b100, 4'b0000};
      tv_instr[8]  = 32'h403100B3;  tv_exp[8]  = {1'b0, 1'b0, 1'b1, 2'b00, 5'b00010, 3'b010, 3'b000, 4'b0000};
      tv_instr[9]  = 32'h00014083;  tv_exp[9]  = {1'b0, 1'b1, 1'b1, 2'b01, 5'b00000, 3'b010, 3'b100, 4'b1100};
      tv_instr[10] = 32'h00311023;  tv_exp[10] = {1'b0, 1'b1, 1'b0, 2'b00, 5'b00000, 3'b010, 3'b010, 4'b1110};
      tv_instr[11] = 32'h00113093;  tv_exp[11] = {1'b0, 1'b1, 1'b1, 2'b00, 5'b01100, 3'b010, 3'b111, 4'b0000};
      tv_instr[12] = 32'h00209463;  tv_exp[12] = {1'b0, 1'b0, 1'b0, 2'b00, 5'b00000, 3'b001, 3'b011, 4'b0000};
      // Back-to-back: one instruction presented and accepted every cycle.
      for (int i = 0; i < 13; i++) begin
         bus.INSTR    = tv_instr[i];
         bus.IN_VALID = 1'b1;
         tick();
         total++; if (bus.OUT_VALID !== 1'b1) begin bad++; $display("FAIL dec_valid[%0d]: got %b want 1", i, bus.OUT_VALID); end
         total++; if (bundle() !== tv_exp[i]) begin bad++; $display("FAIL dec_bundle[%0d]: got %h want %h", i, bundle(), tv_exp[i]); end
      end
      bus.IN_VALID = 1'b0;
      tick();
      total++; if (bus.OUT_VALID !== 1'b0) begin bad++; $display("FAIL dec_idle_valid: got %b want 0", bus.OUT_VALID); end
      total++; if (bundle() !== BUBBLE) begin bad++; $display("FAIL dec_idle_bundle: got %h want %h", bundle(), BUBBLE); end
   endtask

   task automatic test_div();
      int n;
      bus.INSTR    = I_DIV;
      bus.IN_VALID = 1'b1;
      tick();
      total++; if (bus.OUT_VALID !== 1'b1) begin bad++; $display("FAIL div_valid: got %b want 1", bus.OUT_VALID); end
      total++; if (bus.ALUOP !== 5'b10001) begin bad++; $display("FAIL div_aluop: got %b want 10001", bus.ALUOP); end
      total++; if (bus.IN_READY !== 1'b0) begin bad++; $display("FAIL div_in_ready: got %b want 0", bus.IN_READY); end
      // Keep a valid ADD waiting; it must not be taken while busy.
      bus.INSTR = I_ADD;
      n = 0;
      for (int i = 0; i < 200 && bus.MDU_BUSY === 1'b1; i++) begin
         n++;
         tick();
         if (bus.MDU_BUSY === 1'b1) begin
            total++; if (bus.OUT_VALID !== 1'b0) begin bad++; $display("FAIL div_wait_valid[%0d]: got %b want 0", i, bus.OUT_VALID); end
         end
      end
      total++; if (n !== 32) begin bad++; $display("FAIL div_busy_cycles: got %0d want 32", n); end
      total++; if (bus.IN_READY !== 1'b1) begin bad++; $display("FAIL div_ready_after: got %b want 1", bus.IN_READY); end
      tick();
      total++; if (bus.OUT_VALID !== 1'b1 || bus.ALUOP !== 5'b00000) begin bad++; $display("FAIL div_next_add: got valid=%b aluop=%b want 1/00000", bus.OUT_VALID, bus.ALUOP); end
      bus.IN_VALID = 1'b0;
      tick();
   endtask

   task automatic test_mul();
      int n;
      bus.INSTR    = I_MUL;
      bus.IN_VALID = 1'b1;
      tick();
      bus.IN_VALID = 1'b0;
      total++; if (bus.ALUOP !== 5'b00001) begin bad++; $display("FAIL mul_aluop: got %b want 00001", bus.ALUOP); end
      n = 0;
      for (int i = 0; i < 50 && bus.MDU_BUSY === 1'b1; i++) begin
         n++;
         tick();
      end
      total++; if (n !== 1) begin bad++; $display("FAIL mul_busy_cycles: got %0d want 1", n); end
      tick();
   endtask

   task automatic test_stall();
      int n;
      bus.INSTR    = I_DIV;
      bus.IN_VALID = 1'b1;
      tick();
      bus.IN_VALID = 1'b0;
      bus.STALL_IN = 1'b1;
      n = (bus.MDU_BUSY === 1'b1) ? 1 : 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (bus.MDU_BUSY === 1'b1) n++;
         total++; if (bus.OUT_VALID !== 1'b1 || bus.ALUOP !== 5'b10001) begin bad++; $display("FAIL stall_frozen[%0d]: got valid=%b aluop=%b want 1/10001", k, bus.OUT_VALID, bus.ALUOP); end
      end
      bus.STALL_IN = 1'b0;
      for (int i = 0; i < 200 && bus.MDU_BUSY === 1'b1; i++) begin
         tick();
         if (bus.MDU_BUSY === 1'b1) n++;
      end
      total++; if (n !== 37) begin bad++; $display("FAIL stall_busy_cycles: got %0d want 37", n); end
      tick();
   endtask

   task automatic test_flush();
      bus.INSTR    = I_BEQ;
      bus.IN_VALID = 1'b1;
      tick();
      total++; if (bus.OUT_VALID !== 1'b1 || bus.BRANCH_JUMP !== 3'b000) begin bad++; $display("FAIL fl_beq: got valid=%b bj=%b want 1/000", bus.OUT_VALID, bus.BRANCH_JUMP); end
      bus.INSTR = I_ADD;
      bus.FLUSH = 1'b1;
      #1;
      total++; if (bus.IN_READY !== 1'b1) begin bad++; $display("FAIL fl_in_ready: got %b want 1", bus.IN_READY); end
      tick();
      total++; if (bus.OUT_VALID !== 1'b0) begin bad++; $display("FAIL fl_out_valid: got %b want 0", bus.OUT_VALID); end
      total++; if (bundle() !== BUBBLE) begin bad++; $display("FAIL fl_bundle: got %h want %h", bundle(), BUBBLE); end
      bus.FLUSH    = 1'b0;
      bus.IN_VALID = 1'b0;
      tick();
      total++; if (bus.OUT_VALID !== 1'b0) begin bad++; $display("FAIL fl_not_accepted: got %b want 0", bus.OUT_VALID); end
      // Flush coinciding with an M-op: nothing issued, no busy.
      bus.INSTR    = I_DIV;
      bus.IN_VALID = 1'b1;
      bus.FLUSH    = 1'b1;
      tick();
      total++; if (bus.MDU_BUSY !== 1'b0 || bus.OUT_VALID !== 1'b0) begin bad++; $display("FAIL fl_mop: got busy=%b valid=%b want 0/0", bus.MDU_BUSY, bus.OUT_VALID); end
      // Flush in the middle of a divide wait.
      bus.FLUSH = 1'b0;
      tick();
      bus.IN_VALID = 1'b0;
      tick();
      tick();
      total++; if (bus.MDU_BUSY !== 1'b1) begin bad++; $display("FAIL fl_div_busy: got %b want 1", bus.MDU_BUSY); end
      bus.FLUSH = 1'b1;
      tick();
      total++; if (bus.MDU_BUSY !== 1'b0 || bus.IN_READY !== 1'b1) begin bad++; $display("FAIL fl_div_abort: got busy=%b ready=%b want 0/1", bus.MDU_BUSY, bus.IN_READY); end
      bus.FLUSH = 1'b0;
      tick();
      total++; if (bus.MDU_BUSY !== 1'b0) begin bad++; $display("FAIL fl_div_stays_idle: got %b want 0", bus.MDU_BUSY); end
   endtask

   task automatic test_illegal();
      bus.INSTR       = I_BAD;
      bus.IN_VALID    = 1'b1;
      bus_nm.INSTR    = I_MUL;
      bus_nm.IN_VALID = 1'b1;
      tick();
      bus.IN_VALID    = 1'b0;
      bus_nm.IN_VALID = 1'b0;
      total++; if (bus.ILLEGAL !== 1'b1) begin bad++; $display("FAIL ill_op_pulse: got %b want 1", bus.ILLEGAL); end
      total++; if (bus.OUT_VALID !== 1'b0 || bus.REG_WRITE_EN !== 1'b0) begin bad++; $display("FAIL ill_op_bubble: got valid=%b rw=%b want 0/0", bus.OUT_VALID, bus.REG_WRITE_EN); end
      total++; if (bus_nm.ILLEGAL !== 1'b1) begin bad++; $display("FAIL ill_mul_pulse: got %b want 1", bus_nm.ILLEGAL); end
      total++; if (bus_nm.OUT_VALID !== 1'b0 || bus_nm.REG_WRITE_EN !== 1'b0 || bus_nm.MDU_BUSY !== 1'b0) begin bad++; $display("FAIL ill_mul_bubble: got valid=%b rw=%b busy=%b want 0/0/0", bus_nm.OUT_VALID, bus_nm.REG_WRITE_EN, bus_nm.MDU_BUSY); end
      tick();
      total++; if (bus.ILLEGAL !== 1'b0) begin bad++; $display("FAIL ill_op_clear: got %b want 0", bus.ILLEGAL); end
      total++; if (bus_nm.ILLEGAL !== 1'b0) begin bad++; $display("FAIL ill_mul_clear: got %b want 0", bus_nm.ILLEGAL); end
      bus_nm.INSTR    = I_ADD;
      bus_nm.IN_VALID = 1'b1;
      tick();
      bus_nm.IN_VALID = 1'b0;
      total++; if (bus_nm.OUT_VALID !== 1'b1 || bus_nm.ILLEGAL !== 1'b0) begin bad++; $display("FAIL nm_add: got valid=%b ill=%b want 1/0", bus_nm.OUT_VALID, bus_nm.ILLEGAL); end
   endtask

   task automatic test_reset_mid_wait();
      bus.INSTR    = I_DIV;
      bus.IN_VALID = 1'b1;
      tick();
      bus.IN_VALID = 1'b0;
      tick();
      tick();
      total++; if (bus.MDU_BUSY !== 1'b1) begin bad++; $display("FAIL rmw_busy: got %b want 1", bus.MDU_BUSY); end
      resetn = 1'b0;
      #1;
      total++; if (bus.MDU_BUSY !== 1'b0 || bus.IN_READY !== 1'b1 || bus.OUT_VALID !== 1'b0) begin bad++; $display("FAIL rmw_async: got busy=%b ready=%b valid=%b want 0/1/0", bus.MDU_BUSY, bus.IN_READY, bus.OUT_VALID); end
      resetn = 1'b1;
      tick();
   endtask

   initial begin
      resetn          = 1'b0;
      bus.INSTR       = '0;
      bus.IN_VALID    = 1'b0;
      bus.STALL_IN    = 1'b0;
      bus.FLUSH       = 1'b0;
      bus_nm.INSTR    = '0;
      bus_nm.IN_VALID = 1'b0;
      bus_nm.STALL_IN = 1'b0;
      bus_nm.FLUSH    = 1'b0;
      test_reset();
      test_decode_table();
      test_div();
      test_mul();
      test_stall();
      test_flush();
      test_illegal();
      test_reset_mid_wait();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/control_unit_pipelined.md
Name: control_unit_pipelined

Overview:
- Parametrised, registered RV32IM decode/control stage. It sits between the IF/ID register and the ID/EX register, and is itself the control half of ID/EX.
- Decodes INSTR into the standard control bundle one cycle after acceptance.
- Supports stall and flush.
- Runs a small FSM that blocks issue of new instructions while a multi-cycle M-extension operation (MUL*/DIV*/REM*) occupies the execute unit.

Parameters:
- M_EXT, 1, 1 decodes M-extension ops with busy sequencing; 0 treats FUNCT7[0]=1 R-type as illegal.
- MUL_LATENCY, 2, execute cycles for MUL/MULH/MULHSU/MULHU (≥1).
- DIV_LATENCY, 33, execute cycles for DIV/DIVU/REM/REMU (≥1).
- CNT_W, $clog2(max(MUL_LATENCY,DIV_LATENCY)+1), localparam, busy-counter width.

Ports:
- CLK  in  1  rising-edge clock
- RESETN  in  1  asynchronous, active-low reset
- INSTR  in  32  instruction word from IF/ID
- IN_VALID  in  1  INSTR is valid
- IN_READY  out  1  stage accepts INSTR this cycle
- STALL_IN  in  1  downstream hold; all registered outputs keep their value
- FLUSH  in  1  branch/jump taken in EX; kill the registered instruction
- OUT_VALID  out  1  registered bundle is a real instruction
- OP1SEL  out  1  1 = PC, 0 = rs1
- OP2SEL  out  1  1 = immediate, 0 = rs2
- REG_WRITE_EN  out  1  register-file write enable
- WB_SEL  out  2  00 ALU, 01 memory, 10 immediate (LUI), 11 PC+4
- ALUOP  out  5  {FUNCT3, FUNCT7[5], FUNCT7[0]} for R/I types, else 00000 (add)
- BRANCH_JUMP  out  3  010 none, 011 jump, otherwise {FUNCT3} of the branch
- IMM_SEL  out  3  000 U, 001 J, 010 S, 011 B, 100 I, 101 I-shift, 111 I-unsigned
- MEM_RW  out  4  0000 none; LB 1000, LH 1001, LW 1010, LBU 1100, LHU 1101, SB 1011, SH 1110, SW 1111
- MDU_BUSY  out  1  multi-cycle M-op in progress
- ILLEGAL  out  1  one-cycle pulse, aligned with the bubble, for an undecodable opcode

Behaviour:
- Reset (RESETN=0, asynchronous): FSM=IDLE, counter=0, OUT_VALID=0, ILLEGAL=0, MDU_BUSY=0. The bundle holds bubble values: REG_WRITE_EN=0, MEM_RW=0000, BRANCH_JUMP=010, ALUOP=0, WB_SEL=00, OP1SEL=OP2SEL=0, IMM_SEL=000.
- IN_READY = (state==IDLE) & !STALL_IN. It is combinational and is not gated by FLUSH.
- Accept happens when IN_VALID & IN_READY & !FLUSH. The decoded bundle is registered at the next edge, giving 1-cycle latency.
- Priority per edge: FLUSH > STALL_IN > accept > bubble.
  - FLUSH: load the bubble and OUT_VALID=0; force FSM to IDLE and counter to 0, which aborts any busy wait; ILLEGAL=0.
  - STALL_IN (without FLUSH): hold all registers, including the counter.
  - No accept and no stall: load the bubble.
- Illegal opcode: load the bubble with OUT_VALID=0 and ILLEGAL=1 for one cycle.
- I-shift handling: FUNCT7 feeds ALUOP[1:0] only for R-type and for I-shifts (FUNCT3 = 001 or 101); other I-types force ALUOP[1:0]=00.
- FSM states: IDLE, MUL_WAIT, DIV_WAIT.
  - IDLE → MUL_WAIT on accepting an M-op with FUNCT3[2]=0; counter loaded with MUL_LATENCY-1.
  - IDLE → DIV_WAIT on accepting an M-op with FUNCT3[2]=1; counter loaded with DIV_LATENCY-1.
  - If the loaded latency-1 value is 0, stay in IDLE; no busy cycle.
  - In a WAIT state, each non-stalled cycle bubbles the output and decrements the counter. When the counter reaches 0, go to IDLE.
  - MDU_BUSY = (state != IDLE).
- Simultaneous events:
  - FLUSH together with an M-op accept: the flush wins and the FSM stays in IDLE.
  - STALL_IN in a WAIT state: the counter freezes.
  - Reset mid-wait: immediate return to IDLE.

Decomposition:
- Package rv32_ctrl_pkg: opcode constants; WB_SEL, IMM_SEL, BRANCH_JUMP and MEM_RW encodings; the bubble constant; a packed ctrl_bundle_t struct.
- One combinational sub-module, rv32_decode, maps INSTR to ctrl_bundle_t plus is_mop, is_div and illegal.
- The top level holds the registers, counter and FSM.

Test Plan:
- Reset, then release with IN_VALID=0 → OUT_VALID=0, BRANCH_JUMP=010, MEM_RW=0000, IN_READY=1.
- Accept ADD x1,x2,x3 (0x003100B3) → next cycle OUT_VALID=1, REG_WRITE_EN=1, OP2SEL=0, ALUOP=00000, WB_SEL=00. Accept SW x3,0(x2) (0x00312023) → MEM_RW=1111, IMM_SEL=010, REG_WRITE_EN=0.
- Accept DIV x1,x2,x3 (0x023140B3) with DIV_LATENCY=33 → ALUOP=10001 for one cycle, then IN_READY=0 and MDU_BUSY=1 for exactly 32 cycles, then IN_READY=1. Repeat with MUL (0x023100B3) and MUL_LATENCY=2 → exactly 1 busy cycle.
- DIV accepted, then STALL_IN=1 for 5 cycles mid-wait → busy lasts 37 cycles; outputs frozen during the stall.
- BEQ x1,x2,8 (0x00208463) registered, then FLUSH=1 with IN_VALID=1 → next cycle bubble, OUT_VALID=0, and the input is not accepted. FLUSH during DIV_WAIT → next cycle IDLE, MDU_BUSY=0.
- Opcode 0x7F, and M_EXT=0 with a MUL → ILLEGAL=1 for one cycle, OUT_VALID=0, REG_WRITE_EN=0.
